// File: rtl/square_wave_meas.sv
// -----------------------------------------------------------------------------
// square_wave_meas
//
// Purpose
//   Measures a square wave that is already synchronous to clk. It counts how many
//   clock samples the wave spends high (on) and low (off), and reports both once
//   per complete period. A period is closed by the rising edge that follows a
//   high phase and then a low phase. This block is the receive-side partner of
//   the square-wave generator. It can be used for loopback checks of generator
//   settings, or as a duty-cycle monitor on a PWM or enable line.
//
// Parameters
//   N         counter/result width (N >= 2). The longest phase that can be
//             reported is 2^N-1 samples; longer phases saturate and set ovf.
//
// Ports
//   clk       in   1  single clock, all logic on posedge
//   reset_n   in   1  asynchronous active-low reset
//   s_wave    in   1  measured wave, synchronous to clk (no synchroniser inside)
//   on_time   out  N  samples high in the last complete period
//   off_time  out  N  samples low in the last complete period
//   valid     out  1  one-cycle pulse: on_time/off_time/ovf were just updated
//   ovf       out  1  a phase of the reported period exceeded 2^N-1 samples
// -----------------------------------------------------------------------------
module square_wave_meas #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_wave,
    output logic [N-1:0] on_time,
    output logic [N-1:0] off_time,
    output logic         valid,
    output logic         ovf
);

    localparam logic [1:0] ST_SYNC = 2'd0;  // waiting for the first rise
    localparam logic [1:0] ST_HIGH = 2'd1;  // measuring the on-phase
    localparam logic [1:0] ST_LOW  = 2'd2;  // measuring the off-phase

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic         s_r_reg;
    logic [N-1:0] cnt_reg,      cnt_next;
    logic         sat_reg,      sat_next;
    logic [1:0]   state_reg,    state_next;
    logic [N-1:0] on_hold_reg,  on_hold_next;
    logic         ovf_hold_reg, ovf_hold_next;
    logic [N-1:0] on_time_reg,  on_time_next;
    logic [N-1:0] off_time_reg, off_time_next;
    logic         ovf_reg,      ovf_next;
    logic         valid_reg,    valid_next;

    logic rise;
    logic fall;

    // Edges are seen in the same posedge that first samples the new level.
    // s_r_reg clears on reset. So a wave that is already high when reset is
    // released looks like a rise on the first sample after release.
    assign rise = s_wave & ~s_r_reg;
    assign fall = ~s_wave & s_r_reg;

    // ---------------------------------------------------------------------
    // Phase counter: counts the samples seen at the current level.
    // An edge loads 1 because the edge sample itself belongs to the new phase.
    // The counter stops at CNT_MAX. The sat flag is set only when another
    // sample arrives after the counter has reached CNT_MAX. So a phase of
    // exactly CNT_MAX samples is reported as CNT_MAX with no overflow.
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg;
        sat_next = sat_reg;
        if (rise || fall) begin
            cnt_next = CNT_ONE;
            sat_next = 1'b0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end else begin
            sat_next = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Period FSM. The length captured at an edge is the counter value before
    // that edge reloads it. The on-phase length is kept in on_hold until the
    // off-phase closes, so both results are published together.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        on_hold_next  = on_hold_reg;
        ovf_hold_next = ovf_hold_reg;
        on_time_next  = on_time_reg;
        off_time_next = off_time_reg;
        ovf_next      = ovf_reg;
        valid_next    = 1'b0;

        case (state_reg)
            ST_SYNC: begin
                // A fall here ends a partial phase of unknown length, so it
                // is ignored. Measurement starts only at a rise.
                if (rise) begin
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    on_hold_next  = cnt_reg;
                    ovf_hold_next = sat_reg;
                    state_next    = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    on_time_next  = on_hold_reg;
                    off_time_next = cnt_reg;
                    ovf_next      = ovf_hold_reg | sat_reg;
                    valid_next    = 1'b1;
                    state_next    = ST_HIGH;
                end
            end
            default: begin
                state_next = ST_SYNC;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_r_reg      <= 1'b0;
            cnt_reg      <= '0;
            sat_reg      <= 1'b0;
            state_reg    <= ST_SYNC;
            on_hold_reg  <= '0;
            ovf_hold_reg <= 1'b0;
            on_time_reg  <= '0;
            off_time_reg <= '0;
            ovf_reg      <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            s_r_reg      <= s_wave;
            cnt_reg      <= cnt_next;
            sat_reg      <= sat_next;
            state_reg    <= state_next;
            on_hold_reg  <= on_hold_next;
            ovf_hold_reg <= ovf_hold_next;
            on_time_reg  <= on_time_next;
            off_time_reg <= off_time_next;
            ovf_reg      <= ovf_next;
            valid_reg    <= valid_next;
        end
    end

    assign on_time  = on_time_reg;
    assign off_time = off_time_reg;
    assign ovf      = ovf_reg;
    assign valid    = valid_reg;

endmodule
